round_select_pipe: RTL

ROUND_SELECT_PIPE -- requirements
Module: round_select_pipe

---
 rtl/round_select_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/round_select_pipe.sv
// Two-stage valid/ready rounding pipe: stage 1 splits the fraction into
// frac/trailing/sticky, stage 2 applies the selected rounding mode.
module round_select_pipe #(
  parameter int IN_WIDTH      = 12,
  parameter int FRAC          = 8,
  parameter int TRAILING_BITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [IN_WIDTH-1:0] inData,
  input  logic                inSign,
  input  logic [2:0]          inMode,
  output logic                outValid,
  input  logic                outReady,
  output logic [FRAC-1:0]     outFrac,
  output logic                outCarry,
  output logic                outInexact,
  output logic                outSign
);

  localparam int FT = FRAC + TRAILING_BITS;
  localparam int PW = (IN_WIDTH > FT) ? IN_WIDTH : FT;

  // Left-justify the input so short inputs get zero bits below bit 0.
  logic [PW-1:0]            padded;
  logic [FRAC-1:0]          in_frac;
  logic [TRAILING_BITS-1:0] in_trail;
  logic                     in_sticky;

  assign padded   = PW'(inData) << (PW - IN_WIDTH);
  assign in_frac  = padded[PW-1 -: FRAC];
  assign in_trail = padded[PW-FRAC-1 -: TRAILING_BITS];

  generate
    if (PW > FT) begin : g_sticky
      assign in_sticky = |padded[PW-FT-1:0];
    end else begin : g_no_sticky
      assign in_sticky = 1'b0;
    end
  endgenerate

  logic                     s1_valid;
  logic [FRAC-1:0]          s1_frac;
  logic [TRAILING_BITS-1:0] s1_trail;
  logic                     s1_sticky;
  logic                     s1_sign;
  logic [2:0]               s1_mode;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv  = !outValid || outReady;
  assign s1_adv  = !s1_valid || s2_adv;
  assign inReady = s1_adv;

  logic            half;
  logic            rest;
  logic            inexact;
  logic            inc;
  logic [FRAC:0]   sum;

  assign half = s1_trail[TRAILING_BITS-1];

  generate
    if (TRAILING_BITS > 1) begin : g_rest
      assign rest = (|s1_trail[TRAILING_BITS-2:0]) | s1_sticky;
    end else begin : g_rest_sticky
      assign rest = s1_sticky;
    end
  endgenerate

  assign inexact = half | rest;

  // Codes 5-7 fall into the default arm and round to nearest even.
  always_comb begin
    inc = 1'b0;
    case (s1_mode)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inexact & ~s1_sign;
      3'd3:    inc = inexact & s1_sign;
      3'd4:    inc = half;
      default: inc = half & (rest | s1_frac[0]);
    endcase
  end

  assign sum = {1'b0, s1_frac} + {{FRAC{1'b0}}, inc};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_frac    <= '0;
      s1_trail   <= '0;
      s1_sticky  <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mode    <= '0;
      outValid   <= 1'b0;
      outFrac    <= '0;
      outCarry   <= 1'b0;
      outInexact <= 1'b0;
      outSign    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= inValid;
        if (inValid) begin
          s1_frac   <= in_frac;
          s1_trail  <= in_trail;
          s1_sticky <= in_sticky;
          s1_sign   <= inSign;
          s1_mode   <= inMode;
        end
      end
      if (s2_adv) begin
        outValid <= s1_valid;
        if (s1_valid) begin
          outFrac    <= sum[FRAC-1:0];
          outCarry   <= sum[FRAC];
          outInexact <= inexact;
          outSign    <= s1_sign;
        end
      end
    end
  end

endmodule
